// File: rtl/uart_receiver_with_decoder.sv
// uart_receiver_with_decoder
//   Receives 8N1 serial frames (LSB first, line idles high) from the keypress
//   UART transmitter. Each good byte is shown on o_data with a one-cycle
//   o_valid strobe. Its low nibble is decoded onto the {w,d,s,a} key LEDs.
//
// Ports
//   i_clock        system clock (single domain)
//   i_resetL       asynchronous active-low reset
//   i_RX           serial input, asynchronous to i_clock, idle high
//   o_data         last good byte, held until the next good frame
//   o_valid        one-cycle pulse when o_data updates
//   o_frame_error  one-cycle pulse when the stop bit is sampled low
//   o_busy         high in every state except IDLE
//   o_key_leds     {w,d,s,a} flags from the last good byte, held
//
// Build option
//   UART_RX_MAJORITY_VOTE_EN : when defined, every start, data and stop sample
//   is the 2-of-3 majority of rx_s at counts target-1, target and target+1.
//   The decision is made at target+1. When undefined, a single sample is taken
//   at target.

module uart_receiver_with_decoder #(
  parameter int DATA_WIDTH          = 8,
  parameter int BIT_COUNTER_WIDTH   = 3,
  parameter int CLOCK_COUNTER_WIDTH = 9,
  parameter int CLOCKS_PER_BIT      = 434
) (
  input  logic                  i_clock,
  input  logic                  i_resetL,
  input  logic                  i_RX,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_error,
  output logic                  o_busy,
  output logic [3:0]            o_key_leds
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  localparam logic [CLOCK_COUNTER_WIDTH-1:0] HALF_COUNT =
    CLOCK_COUNTER_WIDTH'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] BIT_COUNT =
    CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [BIT_COUNTER_WIDTH-1:0] LAST_BIT =
    BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

  logic                           rx_meta;
  logic                           rx_s;
  logic [2:0]                     state;
  logic [CLOCK_COUNTER_WIDTH-1:0] clk_count;
  logic [BIT_COUNTER_WIDTH-1:0]   bit_index;
  logic [DATA_WIDTH-1:0]          shift_reg;
  logic [CLOCK_COUNTER_WIDTH-1:0] target_count;
  logic                           at_decision;
  logic                           sample;

  // Two-flop synchronizer. The flops reset to the idle-high level so that
  // leaving reset cannot produce a false start edge.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RX;
      rx_s    <= rx_meta;
    end
  end

  // The start bit is checked at half a bit. Data and stop bits are checked a
  // full bit after the previous decision, which lands near each mid-bit.
  assign target_count = (state == START) ? HALF_COUNT : BIT_COUNT;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote_early;
  logic vote_mid;

  // Capture the two samples before the decision point. The third sample is
  // the live rx_s at target+1.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      vote_early <= 1'b1;
      vote_mid   <= 1'b1;
    end else begin
      if (clk_count == target_count - 1'b1) vote_early <= rx_s;
      if (clk_count == target_count)        vote_mid   <= rx_s;
    end
  end

  assign at_decision = (clk_count == target_count + 1'b1);
  assign sample      = (vote_early & vote_mid) | (vote_early & rx_s) | (vote_mid & rx_s);
`else
  assign at_decision = (clk_count == target_count);
  assign sample      = rx_s;
`endif

  // Receive FSM. The counters are cleared on every state change and never
  // run past the decision count.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      state         <= IDLE;
      clk_count     <= '0;
      bit_index     <= '0;
      shift_reg     <= '0;
      o_data        <= '0;
      o_key_leds    <= '0;
      o_valid       <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_valid       <= 1'b0;
      o_frame_error <= 1'b0;
      case (state)
        IDLE: begin
          clk_count <= '0;
          bit_index <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (at_decision) begin
            clk_count <= '0;
            bit_index <= '0;
            // A start bit that is high again at half a bit is a glitch.
            state     <= sample ? IDLE : DATA;
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
        DATA: begin
          if (at_decision) begin
            // The line sends LSB first, so each new bit enters at the top
            // and earlier bits shift down toward bit 0.
            shift_reg <= {sample, shift_reg[DATA_WIDTH-1:1]};
            clk_count <= '0;
            if (bit_index == LAST_BIT) begin
              bit_index <= '0;
              state     <= STOP;
            end else begin
              bit_index <= bit_index + 1'b1;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
        STOP: begin
          if (at_decision) begin
            clk_count <= '0;
            if (sample) begin
              o_data     <= shift_reg;
              o_key_leds <= shift_reg[3:0];
              o_valid    <= 1'b1;
              state      <= IDLE;
            end else begin
              o_frame_error <= 1'b1;
              state         <= WAIT_IDLE;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // A break or stuck-low line must not be taken as a new start bit.
          clk_count <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          clk_count <= '0;
          bit_index <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver_with_decoder.sv
// tb_uart_receiver_with_decoder
//   Drives serial frames into uart_receiver_with_decoder. Expected bytes go
//   into a queue as frames are sent. A negedge monitor pops and compares them
//   whenever o_valid pulses.

module tb_uart_receiver_with_decoder;

  localparam int CLOCKS_PER_BIT = 434;
  localparam int SAMPLE_OFFSET  = (CLOCKS_PER_BIT - 1) / 2 + 1;
  localparam int MIN_LATENCY    = 4123;
  localparam int MAX_LATENCY    = 4136;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [7:0] GLITCH_EXPECT = 8'hA5;
`else
  localparam logic [7:0] GLITCH_EXPECT = 8'h5A;
`endif

  logic       clock = 1'b0;
  logic       i_resetL;
  logic       i_RX;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_error;
  logic       o_busy;
  logic [3:0] o_key_leds;

  int check_count     = 0;
  int error_count     = 0;
  int cycle_count     = 0;
  int valid_count     = 0;
  int frame_err_count = 0;
  int last_valid_cycle = 0;
  int frame_start     = 0;
  logic [7:0] expected_q[$];

  uart_receiver_with_decoder dut (
    .i_clock       (clock),
    .i_resetL      (i_resetL),
    .i_RX          (i_RX),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_frame_error (o_frame_error),
    .o_busy        (o_busy),
    .o_key_leds    (o_key_leds)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle_count <= cycle_count + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Monitor: every o_valid cycle must match the oldest expected byte.
  always @(negedge clock) begin
    if (i_resetL) begin
      if (o_valid || o_frame_error)
        checkOutput("valid_ferr_exclusive", 32'(o_valid & o_frame_error), 32'd0);
      if (o_frame_error) frame_err_count++;
      if (o_valid) begin
        valid_count++;
        last_valid_cycle = cycle_count;
        if (expected_q.size() == 0) begin
          checkOutput("unexpected_valid", 32'd1, 32'd0);
        end else begin
          logic [7:0] exp_byte;
          exp_byte = expected_q.pop_front();
          checkOutput("rx_data", 32'(o_data), 32'(exp_byte));
          checkOutput("rx_leds", 32'(o_key_leds), 32'(exp_byte[3:0]));
        end
      end
    end
  end

  task automatic driveLevel(input logic level, input int cycles, input bit glitch);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clock);
      #1;
      i_RX = (glitch && c == SAMPLE_OFFSET) ? ~level : level;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data_byte, input int stop_cycles,
                               input logic stop_level, input bit glitch);
    @(posedge clock);
    #1;
    frame_start = cycle_count;
    i_RX = 1'b0;
    driveLevel(1'b0, CLOCKS_PER_BIT - 1, 1'b0);
    for (int i = 0; i < 8; i++) driveLevel(data_byte[i], CLOCKS_PER_BIT, glitch);
    driveLevel(stop_level, stop_cycles, 1'b0);
  endtask

  initial begin
    #(200000 * 10);
    $display("[TB] FAIL watchdog expired before the test sequence finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int saved_valid;
    logic [7:0] partial_byte;
    partial_byte = 8'h3C;

    i_resetL = 1'b0;
    i_RX     = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("reset_data",  32'(o_data), 32'd0);
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_ferr",  32'(o_frame_error), 32'd0);
    checkOutput("reset_busy",  32'(o_busy), 32'd0);
    checkOutput("reset_leds",  32'(o_key_leds), 32'd0);
    i_resetL = 1'b1;
    driveLevel(1'b1, 20, 1'b0);

    // Single frame 0x05 (a+d) with a one-bit stop.
    expected_q.push_back(8'h05);
    applyStimulus(8'h05, CLOCKS_PER_BIT, 1'b1, 1'b0);
    driveLevel(1'b1, 20, 1'b0);
    checkOutput("frame05_valid_count", 32'(valid_count), 32'd1);
    checkOutput("frame05_leds", 32'(o_key_leds), 32'b0101);
    checkOutput("frame05_no_ferr", 32'(frame_err_count), 32'd0);
    checkOutput("frame05_latency_in_range",
                32'((last_valid_cycle - frame_start) >= MIN_LATENCY &&
                    (last_valid_cycle - frame_start) <= MAX_LATENCY), 32'd1);

    // 100-cycle low glitch from idle.
    @(posedge clock);
    #1;
    i_RX = 1'b0;
    driveLevel(1'b0, 49, 1'b0);
    checkOutput("glitch_busy_mid", 32'(o_busy), 32'd1);
    driveLevel(1'b0, 50, 1'b0);
    driveLevel(1'b1, 2 * CLOCKS_PER_BIT, 1'b0);
    checkOutput("glitch_idle", 32'(o_busy), 32'd0);
    checkOutput("glitch_no_valid", 32'(valid_count), 32'd1);
    checkOutput("glitch_no_ferr", 32'(frame_err_count), 32'd0);
    checkOutput("glitch_data_held", 32'(o_data), 32'h05);

    // Frame 0x0A with a low stop bit and the line held low for 5 bit times.
    applyStimulus(8'h0A, 5 * CLOCKS_PER_BIT, 1'b0, 1'b0);
    checkOutput("ferr_count", 32'(frame_err_count), 32'd1);
    checkOutput("ferr_busy_while_low", 32'(o_busy), 32'd1);
    checkOutput("ferr_data_held", 32'(o_data), 32'h05);
    checkOutput("ferr_leds_held", 32'(o_key_leds), 32'b0101);
    driveLevel(1'b1, 10, 1'b0);
    checkOutput("ferr_busy_released", 32'(o_busy), 32'd0);
    expected_q.push_back(8'h08);
    applyStimulus(8'h08, CLOCKS_PER_BIT, 1'b1, 1'b0);
    driveLevel(1'b1, 20, 1'b0);
    checkOutput("after_ferr_leds", 32'(o_key_leds), 32'b1000);

    // Reset in the middle of data bit 4.
    saved_valid = valid_count;
    @(posedge clock);
    #1;
    i_RX = 1'b0;
    driveLevel(1'b0, CLOCKS_PER_BIT - 1, 1'b0);
    for (int i = 0; i < 4; i++) driveLevel(partial_byte[i], CLOCKS_PER_BIT, 1'b0);
    driveLevel(partial_byte[4], 200, 1'b0);
    i_resetL = 1'b0;
    i_RX     = 1'b1;
    #1;
    checkOutput("midreset_data", 32'(o_data), 32'd0);
    checkOutput("midreset_busy", 32'(o_busy), 32'd0);
    checkOutput("midreset_leds", 32'(o_key_leds), 32'd0);
    checkOutput("midreset_valid", 32'(o_valid), 32'd0);
    repeat (5) @(posedge clock);
    #1;
    i_resetL = 1'b1;
    driveLevel(1'b1, 2 * CLOCKS_PER_BIT, 1'b0);
    checkOutput("midreset_no_pulse", 32'(valid_count), 32'(saved_valid));
    checkOutput("midreset_data_after", 32'(o_data), 32'd0);
    expected_q.push_back(8'h02);
    applyStimulus(8'h02, CLOCKS_PER_BIT, 1'b1, 1'b0);
    driveLevel(1'b1, 20, 1'b0);
    checkOutput("after_reset_frame", 32'(valid_count), 32'(saved_valid + 1));

    // Back-to-back frames with a minimal stop gap.
    saved_valid = valid_count;
    expected_q.push_back(8'h01);
    expected_q.push_back(8'h02);
    expected_q.push_back(8'h04);
    applyStimulus(8'h01, CLOCKS_PER_BIT, 1'b1, 1'b0);
    applyStimulus(8'h02, CLOCKS_PER_BIT, 1'b1, 1'b0);
    applyStimulus(8'h04, CLOCKS_PER_BIT, 1'b1, 1'b0);
    driveLevel(1'b1, 20, 1'b0);
    checkOutput("b2b_valid_count", 32'(valid_count), 32'(saved_valid + 3));
    checkOutput("b2b_last_data", 32'(o_data), 32'h04);

    // Frame 0xA5 with a one-cycle inverted glitch at every data mid-sample.
    expected_q.push_back(GLITCH_EXPECT);
    applyStimulus(8'hA5, CLOCKS_PER_BIT, 1'b1, 1'b1);
    driveLevel(1'b1, 20, 1'b0);
    checkOutput("glitch_frame_data", 32'(o_data), 32'(GLITCH_EXPECT));

    checkOutput("queue_drained", 32'(expected_q.size()), 32'd0);
    checkOutput("total_valid", 32'(valid_count), 32'd7);
    checkOutput("total_ferr", 32'(frame_err_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
